// File: rtl/div_seq_pkg.sv
// Shared types and constants for the divider sequencer: FSM states,
// operation encodings and the result-word slice positions.
package div_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

    // bit0 selects the unsigned IP, bit1 selects the remainder half
    localparam logic [1:0] DIV_OP_DIV_W  = 2'b00;
    localparam logic [1:0] DIV_OP_DIV_WU = 2'b01;
    localparam logic [1:0] DIV_OP_MOD_W  = 2'b10;
    localparam logic [1:0] DIV_OP_MOD_WU = 2'b11;

    localparam int OP_UNSIGNED_BIT  = 0;
    localparam int OP_REMAINDER_BIT = 1;

    // IP output word layout: quotient in the upper half, remainder in the lower
    localparam int QUO_MSB = 63;
    localparam int QUO_LSB = 32;
    localparam int REM_MSB = 31;
    localparam int REM_LSB = 0;

    function automatic logic [31:0] select_half(input logic [1:0] op, input logic [63:0] dout);
        return op[OP_REMAINDER_BIT] ? dout[REM_MSB:REM_LSB] : dout[QUO_MSB:QUO_LSB];
    endfunction

endpackage

// File: rtl/div_sequencer_if.sv
// Request/response handshake between the EX stage and the divide sequencer.
interface div_sequencer_if;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_src1;
    logic [31:0] req_src2;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_result;

    // EX side: issues requests and consumes results
    modport master (
        output req_valid, req_op, req_src1, req_src2, resp_ready,
        input  req_ready, resp_valid, resp_result
    );

    // Sequencer side
    modport slave (
        input  req_valid, req_op, req_src1, req_src2, resp_ready,
        output req_ready, resp_valid, resp_result
    );
endinterface

// File: rtl/axis_src_slot.sv
// One AXI-stream source channel: raises tvalid while active until its
// handshake completes, remembering completion in an accepted flag that is
// cleared when a new operation starts.
module axis_src_slot (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic active,
    input  logic tready,
    output logic tvalid,
    output logic done
);
    logic accepted_reg;

    assign tvalid = active && !accepted_reg;
    // done also covers a handshake happening in the current cycle
    assign done   = accepted_reg || (tvalid && tready);

    // Accepted flag: cleared on start, set on handshake
    always_ff @(posedge clk) begin
        if (reset) begin
            accepted_reg <= 1'b0;
        end else if (start) begin
            accepted_reg <= 1'b0;
        end else if (tvalid && tready) begin
            accepted_reg <= 1'b1;
        end
    end
endmodule

// File: rtl/div_sequencer.sv
// Sequences the shared signed/unsigned divider IPs for the EX stage: one
// request at a time, operands latched on accept, result half selected from
// the IP output. A cancel drains any in-flight IP operation so that its
// result is swallowed rather than returned to a later request.
module div_sequencer
    import div_seq_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    div_sequencer_if.slave      bus,
    input  logic                cancel,
    output logic                busy,
    output logic [31:0]         div_dividend_tdata,
    output logic [31:0]         div_divisor_tdata,
    output logic                sdiv_dividend_tvalid,
    output logic                sdiv_divisor_tvalid,
    input  logic                sdiv_dividend_tready,
    input  logic                sdiv_divisor_tready,
    input  logic                sdiv_dout_tvalid,
    input  logic [63:0]         sdiv_dout_tdata,
    output logic                udiv_dividend_tvalid,
    output logic                udiv_divisor_tvalid,
    input  logic                udiv_dividend_tready,
    input  logic                udiv_divisor_tready,
    input  logic                udiv_dout_tvalid,
    input  logic [63:0]         udiv_dout_tdata
);
    state_t      state_reg, state_next;
    logic [1:0]  op_reg;
    logic [31:0] src1_reg, src2_reg, result_reg;

    logic accept, capture, req_ready_next, resp_valid_next;
    logic slot_active, both_done;
    logic sel_unsigned, sel_dout_valid;
    logic [63:0] sel_dout_data;

    // Channel index 0 = dividend, 1 = divisor
    logic slot_tready [2];
    logic slot_tvalid [2];
    logic slot_done   [2];

    assign sel_unsigned   = op_reg[OP_UNSIGNED_BIT];
    assign sel_dout_valid = sel_unsigned ? udiv_dout_tvalid : sdiv_dout_tvalid;
    assign sel_dout_data  = sel_unsigned ? udiv_dout_tdata  : sdiv_dout_tdata;

    assign slot_tready[0] = sel_unsigned ? udiv_dividend_tready : sdiv_dividend_tready;
    assign slot_tready[1] = sel_unsigned ? udiv_divisor_tready  : sdiv_divisor_tready;

    // Unaccepted channels keep being offered while draining too, so the IP
    // always sees a complete operand pair and produces exactly one output.
    assign slot_active = (state_reg == ST_ISSUE) || (state_reg == ST_DRAIN);
    assign both_done   = slot_done[0] && slot_done[1];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_slot
            axis_src_slot u_slot (
                .clk    (clk),
                .reset  (reset),
                .start  (accept),
                .active (slot_active),
                .tready (slot_tready[gi]),
                .tvalid (slot_tvalid[gi]),
                .done   (slot_done[gi])
            );
        end
    endgenerate

    assign sdiv_dividend_tvalid = slot_tvalid[0] && !sel_unsigned;
    assign sdiv_divisor_tvalid  = slot_tvalid[1] && !sel_unsigned;
    assign udiv_dividend_tvalid = slot_tvalid[0] &&  sel_unsigned;
    assign udiv_divisor_tvalid  = slot_tvalid[1] &&  sel_unsigned;

    assign div_dividend_tdata = src1_reg;
    assign div_divisor_tdata  = src2_reg;

    assign bus.req_ready   = req_ready_next;
    assign bus.resp_valid  = resp_valid_next;
    assign bus.resp_result = result_reg;
    assign busy            = (state_reg != ST_IDLE);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Operand registers: only change when a request is accepted
    always_ff @(posedge clk) begin
        if (reset) begin
            op_reg   <= 2'b00;
            src1_reg <= 32'd0;
            src2_reg <= 32'd0;
        end else if (accept) begin
            op_reg   <= bus.req_op;
            src1_reg <= bus.req_src1;
            src2_reg <= bus.req_src2;
        end
    end

    // Result register: captures the selected half when the IP answers
    always_ff @(posedge clk) begin
        if (reset) begin
            result_reg <= 32'd0;
        end else if (capture) begin
            result_reg <= select_half(op_reg, sel_dout_data);
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        state_next      = state_reg;
        accept          = 1'b0;
        capture         = 1'b0;
        req_ready_next  = 1'b0;
        resp_valid_next = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                req_ready_next = 1'b1;
                if (bus.req_valid && !cancel) begin
                    accept     = 1'b1;
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (cancel) begin
                    state_next = ST_DRAIN;
                end else if (both_done) begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A cancel coinciding with the IP output already drains it,
                // so going to DRAIN would wait for an output that never comes.
                if (sel_dout_valid) begin
                    if (cancel) begin
                        state_next = ST_IDLE;
                    end else begin
                        capture    = 1'b1;
                        state_next = ST_DONE;
                    end
                end else if (cancel) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DONE: begin
                resp_valid_next = 1'b1;
                if (cancel || bus.resp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (both_done && sel_dout_valid) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end
endmodule

// File: tb/tb_div_sequencer.sv
// Bench for div_sequencer: behavioural models of both divider IPs, a table
// of operations with a result scoreboard, and hand-written sequences for the
// multi-cycle corners (split handshakes, cancel, backpressure, reset).
module tb_div_sequencer;
    import div_seq_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic cancel;
    logic busy;
    logic [31:0] div_dividend_tdata, div_divisor_tdata;
    logic sdiv_dividend_tvalid, sdiv_divisor_tvalid, sdiv_dividend_tready, sdiv_divisor_tready;
    logic sdiv_dout_tvalid;
    logic [63:0] sdiv_dout_tdata;
    logic udiv_dividend_tvalid, udiv_divisor_tvalid, udiv_dividend_tready, udiv_divisor_tready;
    logic udiv_dout_tvalid;
    logic [63:0] udiv_dout_tdata;

    div_sequencer_if bus();

    always #5 clk = ~clk;

    div_sequencer dut (
        .clk                  (clk),
        .reset                (reset),
        .bus                  (bus),
        .cancel               (cancel),
        .busy                 (busy),
        .div_dividend_tdata   (div_dividend_tdata),
        .div_divisor_tdata    (div_divisor_tdata),
        .sdiv_dividend_tvalid (sdiv_dividend_tvalid),
        .sdiv_divisor_tvalid  (sdiv_divisor_tvalid),
        .sdiv_dividend_tready (sdiv_dividend_tready),
        .sdiv_divisor_tready  (sdiv_divisor_tready),
        .sdiv_dout_tvalid     (sdiv_dout_tvalid),
        .sdiv_dout_tdata      (sdiv_dout_tdata),
        .udiv_dividend_tvalid (udiv_dividend_tvalid),
        .udiv_divisor_tvalid  (udiv_divisor_tvalid),
        .udiv_dividend_tready (udiv_dividend_tready),
        .udiv_divisor_tready  (udiv_divisor_tready),
        .udiv_dout_tvalid     (udiv_dout_tvalid),
        .udiv_dout_tdata      (udiv_dout_tdata)
    );

    // ---------------- IP models (index 0 = signed, 1 = unsigned) ----------
    logic        ip_dvd_tvalid [2];
    logic        ip_dsr_tvalid [2];
    logic        ip_dvd_rdy    [2];
    logic        ip_dsr_rdy    [2];
    logic        ip_dout_valid [2];
    logic [63:0] ip_dout       [2];

    assign ip_dvd_tvalid[0]     = sdiv_dividend_tvalid;
    assign ip_dsr_tvalid[0]     = sdiv_divisor_tvalid;
    assign ip_dvd_tvalid[1]     = udiv_dividend_tvalid;
    assign ip_dsr_tvalid[1]     = udiv_divisor_tvalid;
    assign sdiv_dividend_tready = ip_dvd_rdy[0];
    assign sdiv_divisor_tready  = ip_dsr_rdy[0];
    assign udiv_dividend_tready = ip_dvd_rdy[1];
    assign udiv_divisor_tready  = ip_dsr_rdy[1];
    assign sdiv_dout_tvalid     = ip_dout_valid[0];
    assign sdiv_dout_tdata      = ip_dout[0];
    assign udiv_dout_tvalid     = ip_dout_valid[1];
    assign udiv_dout_tdata      = ip_dout[1];

    function automatic logic [63:0] ip_compute(input bit uns, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q, r;
        if (b == 32'd0) return {32'hFFFF_FFFF, a};
        if (uns) begin
            q = a / b;
            r = a % b;
        end else begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end
        return {q, r};
    endfunction

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ip
            logic        got_a, got_b, computing, dv;
            logic [31:0] a, b;
            logic [2:0]  cnt;
            logic [63:0] dout;
            assign ip_dout_valid[gi] = dv;
            assign ip_dout[gi]       = dout;
            always @(posedge clk) begin
                if (reset) begin
                    got_a <= 1'b0; got_b <= 1'b0; computing <= 1'b0; dv <= 1'b0;
                    cnt <= 3'd0; a <= 32'd0; b <= 32'd0; dout <= 64'd0;
                end else begin
                    dv <= 1'b0;
                    if (ip_dvd_tvalid[gi] && ip_dvd_rdy[gi]) begin got_a <= 1'b1; a <= div_dividend_tdata; end
                    if (ip_dsr_tvalid[gi] && ip_dsr_rdy[gi]) begin got_b <= 1'b1; b <= div_divisor_tdata; end
                    if (got_a && got_b) begin
                        got_a <= 1'b0; got_b <= 1'b0; computing <= 1'b1; cnt <= 3'd3;
                    end else if (computing) begin
                        if (cnt == 3'd1) begin
                            computing <= 1'b0;
                            dv        <= 1'b1;
                            dout      <= ip_compute(gi == 1, a, b);
                        end else begin
                            cnt <= cnt - 3'd1;
                        end
                    end
                end
            end
        end
    endgenerate

    // Cycles in which each IP saw any tvalid
    int tv_s = 0;
    int tv_u = 0;
    always @(posedge clk) begin
        if (sdiv_dividend_tvalid || sdiv_divisor_tvalid) tv_s <= tv_s + 1;
        if (udiv_dividend_tvalid || udiv_divisor_tvalid) tv_u <= tv_u + 1;
    end

    // ---------------- checking helpers ------------------------------------
    int checks = 0;
    int passes = 0;
    logic [31:0] sb [$];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input bit push);
        int n = 0;
        while (!bus.req_ready && n < 50) begin tick(); n++; end
        check32("req_ready_before_issue", {31'd0, bus.req_ready}, 32'd1);
        bus.req_op = op; bus.req_src1 = a; bus.req_src2 = b; bus.req_valid = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        if (push) sb.push_back(exp);
        check32("dividend_tdata", div_dividend_tdata, a);
        check32("issue_tvalid", {31'd0, op[0] ? udiv_dividend_tvalid : sdiv_dividend_tvalid}, 32'd1);
    endtask

    task automatic wait_resp_valid();
        int n = 0;
        while (!bus.resp_valid && n < 200) begin tick(); n++; end
        check32("resp_valid_arrives", {31'd0, bus.resp_valid}, 32'd1);
    endtask

    task automatic finish_resp();
        logic [31:0] exp;
        wait_resp_valid();
        if (bus.resp_valid && sb.size() > 0) begin
            exp = sb.pop_front();
            check32("resp_result", bus.resp_result, exp);
            $display("txn: result %h expected %h", bus.resp_result, exp);
            bus.resp_ready = 1'b1;
            tick();
            bus.resp_ready = 1'b0;
            check32("idle_after_resp", {31'd0, bus.req_ready}, 32'd1);
            check32("resp_valid_drop", {31'd0, bus.resp_valid}, 32'd0);
        end
    endtask

    typedef struct packed {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [6];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, u0;
        int n;
        int rv_seen;
        logic prev_dout;

        vecs[0] = '{DIV_OP_DIV_W,  32'hFFFF_FFF9, 32'd2,  32'hFFFF_FFFD};
        vecs[1] = '{DIV_OP_MOD_WU, 32'hFFFF_FFFF, 32'h10, 32'h0000_000F};
        vecs[2] = '{DIV_OP_MOD_W,  32'hFFFF_FFF9, 32'd2,  32'hFFFF_FFFF};
        vecs[3] = '{DIV_OP_DIV_WU, 32'hFFFF_FFF9, 32'd2,  32'h7FFF_FFFC};
        vecs[4] = '{DIV_OP_DIV_W,  32'd50,        32'd5,  32'd10};
        vecs[5] = '{DIV_OP_MOD_W,  32'd50,        32'd7,  32'd1};

        reset = 1'b1; cancel = 1'b0;
        bus.req_valid = 1'b0; bus.req_op = 2'b00; bus.req_src1 = 32'd0; bus.req_src2 = 32'd0;
        bus.resp_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin ip_dvd_rdy[i] = 1'b1; ip_dsr_rdy[i] = 1'b1; end
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // Reset state
        check32("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        check32("rst_busy", {31'd0, busy}, 32'd0);
        check32("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        check32("rst_resp_result", bus.resp_result, 32'd0);
        check32("rst_tdata", div_dividend_tdata | div_divisor_tdata, 32'd0);
        check32("rst_tvalids", {28'd0, sdiv_dividend_tvalid, sdiv_divisor_tvalid,
                                udiv_dividend_tvalid, udiv_divisor_tvalid}, 32'd0);

        // Table-driven operations; only the selected IP may see tvalid
        for (int i = 0; i < 6; i++) begin
            s0 = tv_s; u0 = tv_u;
            issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, 1'b1);
            finish_resp();
            if (vecs[i].op[0]) begin
                check32("unselected_sdiv_tvalid", tv_s - s0, 32'd0);
                check32("selected_udiv_tvalid", {31'd0, (tv_u - u0) > 0}, 32'd1);
            end else begin
                check32("unselected_udiv_tvalid", tv_u - u0, 32'd0);
                check32("selected_sdiv_tvalid", {31'd0, (tv_s - s0) > 0}, 32'd1);
            end
        end

        // div.wu 100/7 with the divisor handshake 3 cycles after the dividend
        ip_dsr_rdy[1] = 1'b0;
        issue(DIV_OP_DIV_WU, 32'd100, 32'd7, 32'd14, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check32("split_dividend_dropped", {31'd0, udiv_dividend_tvalid}, 32'd0);
            check32("split_divisor_held", {31'd0, udiv_divisor_tvalid}, 32'd1);
        end
        ip_dsr_rdy[1] = 1'b1;
        tick();
        check32("split_divisor_done", {31'd0, udiv_divisor_tvalid}, 32'd0);
        finish_resp();

        // Cancel one cycle after entering WAIT: result drained, never returned
        issue(DIV_OP_DIV_W, 32'd50, 32'd5, 32'd10, 1'b0);
        tick();
        tick();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        n = 0; rv_seen = 0; prev_dout = 1'b0;
        while (busy && n < 50) begin
            if (bus.resp_valid) rv_seen++;
            prev_dout = sdiv_dout_tvalid;
            tick();
            n++;
        end
        check32("drain_no_resp_valid", rv_seen, 32'd0);
        check32("drain_idle", {31'd0, busy}, 32'd0);
        check32("drain_ends_after_dout", {31'd0, prev_dout}, 32'd1);
        issue(DIV_OP_MOD_W, 32'd50, 32'd7, 32'd1, 1'b1);
        finish_resp();

        // Backpressure in DONE: result held, no new request accepted
        issue(DIV_OP_DIV_W, 32'd50, 32'd5, 32'd10, 1'b1);
        wait_resp_valid();
        for (int i = 0; i < 5; i++) begin
            tick();
            check32("hold_resp_valid", {31'd0, bus.resp_valid}, 32'd1);
            check32("hold_resp_result", bus.resp_result, 32'd10);
            check32("hold_req_ready", {31'd0, bus.req_ready}, 32'd0);
        end
        finish_resp();

        // Cancel in DONE drops the result without a handshake
        issue(DIV_OP_DIV_WU, 32'd9, 32'd3, 32'd3, 1'b0);
        wait_resp_valid();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check32("done_cancel_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        check32("done_cancel_req_ready", {31'd0, bus.req_ready}, 32'd1);

        // Request together with cancel in IDLE is dropped
        bus.req_valid = 1'b1; cancel = 1'b1;
        tick();
        bus.req_valid = 1'b0; cancel = 1'b0;
        check32("idle_cancel_busy", {31'd0, busy}, 32'd0);

        // Reset while in ISSUE with tvalid high
        ip_dvd_rdy[0] = 1'b0; ip_dsr_rdy[0] = 1'b0;
        issue(DIV_OP_DIV_W, 32'd77, 32'd7, 32'd11, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        ip_dvd_rdy[0] = 1'b1; ip_dsr_rdy[0] = 1'b1;
        check32("rst_mid_tvalids", {28'd0, sdiv_dividend_tvalid, sdiv_divisor_tvalid,
                                    udiv_dividend_tvalid, udiv_divisor_tvalid}, 32'd0);
        check32("rst_mid_busy", {31'd0, busy}, 32'd0);
        check32("rst_mid_req_ready", {31'd0, bus.req_ready}, 32'd1);
        check32("rst_mid_tdata", div_dividend_tdata, 32'd0);

        // Recovery after reset
        issue(DIV_OP_DIV_W, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b1);
        finish_resp();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/div_sequencer.md
# div_sequencer

Sequences the shared signed/unsigned radix divider IPs on behalf of the EX stage. Accepts one div.w/div.wu/mod.w/mod.wu request at a time and latches the operands. Drives the AXI-stream dividend/divisor handshakes of the selected IP, waits for its output and returns the selected 32-bit half. Supports pipeline flush (cancel) by draining any in-flight IP operation so a stale result is never returned.

## Interface
Parameters: none.

- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- req_valid  in  1  EX presents a divide request.
- req_ready  out  1  sequencer can accept a request (state IDLE).
- req_op  in  2  00 div.w, 01 div.wu, 10 mod.w, 11 mod.wu; bit0 = unsigned, bit1 = remainder.
- req_src1  in  32  dividend (rj).
- req_src2  in  32  divisor (rkd).
- cancel  in  1  flush from exception/ertn; abandons current request.
- resp_valid  out  1  result available.
- resp_ready  in  1  EX/MEM consumes result.
- resp_result  out  32  selected quotient or remainder.
- busy  out  1  state != IDLE.
- div_dividend_tdata  out  32  latched dividend, shared by both IPs.
- div_divisor_tdata  out  32  latched divisor, shared by both IPs.
- sdiv_dividend_tvalid / sdiv_divisor_tvalid  out  1  each  signed IP input channel valids.
- sdiv_dividend_tready / sdiv_divisor_tready  in  1  each  signed IP input channel readies.
- sdiv_dout_tvalid  in  1  signed IP output valid.
- sdiv_dout_tdata  in  64  [63:32] quotient, [31:0] remainder.
- udiv_* : the same six ports for the unsigned IP.

## Operation
- States: IDLE, ISSUE, WAIT, DONE, DRAIN.
- IDLE: req_ready=1. Request is accepted when req_valid && req_ready && !cancel.
  - On accept, latch src1, src2 and op, clear both channel-accepted flags, and go to ISSUE.
  - If req_valid and cancel are high together, the request is dropped.
- ISSUE: the selected IP (op[0]) raises tvalid on each channel whose accepted flag is clear.
  - A channel's flag sets on tvalid && tready.
  - Channels may complete in different cycles. Once raised, tvalid stays high until its handshake completes, per AXI-stream.
  - When both flags are set, or become set this cycle, go to WAIT.
- WAIT: on the selected IP's dout_tvalid, capture the result and go to DONE.
  - Result: op[1]=0 → [63:32]; op[1]=1 → [31:0].
  - dout_tvalid from the non-selected IP is ignored.
- DONE: resp_valid=1, resp_result held stable; on resp_ready go to IDLE.
- cancel:
  - In ISSUE or WAIT → DRAIN.
  - In DONE → IDLE with no handshake.
  - In IDLE → no effect beyond dropping a same-cycle request.
  - In DRAIN → no effect.
- DRAIN: keep driving unaccepted tvalids until both flags are set, then wait for the selected dout_tvalid, discard it, and go to IDLE. resp_valid=0 throughout.
- Divide by zero gets no special casing; the result is whatever the IP returns.
- tdata outputs change only on request accept.

## Timing
- Reset values: state IDLE; all tvalid=0, resp_valid=0, busy=0, resp_result=0, tdata=0, flags clear. req_ready=1 after reset.
- Request accepted in cycle T → ISSUE in T+1 with tvalid=1.
- Both treadys high in T+1 → WAIT from T+2.
- dout_tvalid in cycle D → resp_valid from D+1.
- Added latency over the IP is 2 cycles (issue register plus result register).
- resp_ready sampled in DONE → IDLE next cycle. A new request is accepted no earlier than the following cycle; no same-cycle turnaround.
- Reset mid-operation: everything returns to reset values next cycle. The IPs are reset by the same reset.

## Structure
- Package div_seq_pkg: state enum, DIV_OP_* encodings, quotient/remainder slice constants.
- Sub-module axis_src_slot: one AXI-stream source channel (tvalid generation plus accepted flag, clear on start). Instantiated twice (dividend, divisor); outputs are demuxed to the sdiv_*/udiv_* ports by the latched op[0].

## Test plan
- div.w, src1=0xFFFFFFF9 (-7), src2=2, treadys always high → resp_result=0xFFFFFFFD, and only sdiv tvalids ever assert.
- mod.wu, src1=0xFFFFFFFF, src2=0x10 → resp_result=0x0000000F, and only udiv tvalids assert.
- div.wu 100/7 with divisor tready delayed 3 cycles after dividend tready → dividend tvalid drops after its handshake, divisor tvalid holds 3 cycles; result 14.
- cancel one cycle after entering WAIT on div.w 50/5 → no resp_valid and busy until dout_tvalid+1; a following mod.w 50/7 returns 1.
- resp_ready low for 5 cycles in DONE → resp_valid and resp_result stay constant, req_ready=0 throughout.
- reset asserted while in ISSUE with tvalid high → next cycle all tvalid=0, busy=0, req_ready=1.
